// File: rtl/pe_alloc_pkg.sv
// Shared types and cluster geometry for the mesh PE allocator.
// Four 4x4 clusters, each with a reserved controller PE that is never allocated.
package pe_alloc_pkg;

    typedef enum logic [1:0] {
        CL_MTC  = 2'd0,
        CL_STC1 = 2'd1,
        CL_STC2 = 2'd2,
        CL_STC3 = 2'd3
    } cluster_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_GRANT  = 2'd3
    } state_e;

    localparam int         N_CL       = 4;
    localparam logic [3:0] LOCAL_FULL = 4'd15;

    // Packed tables: element [i] belongs to cluster i.
    localparam logic [3:0][1:0] CTRL_R  = {2'd3, 2'd3, 2'd0, 2'd0};
    localparam logic [3:0][1:0] CTRL_C  = {2'd0, 2'd3, 2'd3, 2'd0};
    localparam logic [3:0][5:0] ID_BASE = {6'd32, 6'd36, 6'd4, 6'd0};
    localparam logic [3:0][5:0] CTRL_ID = {6'd56, 6'd63, 6'd7, 6'd0};

    function automatic logic [3:0] ctrl_k(input logic [1:0] cl);
        return {CTRL_R[cl], CTRL_C[cl]};
    endfunction

    function automatic logic [2:0] manhattan(input logic [1:0] r, input logic [1:0] c,
                                             input logic [1:0] cr, input logic [1:0] cc);
        logic [2:0] dr;
        logic [2:0] dc;
        dr = (r >= cr) ? ({1'b0, r} - {1'b0, cr}) : ({1'b0, cr} - {1'b0, r});
        dc = (c >= cc) ? ({1'b0, c} - {1'b0, cc}) : ({1'b0, cc} - {1'b0, c});
        return dr + dc;
    endfunction

    function automatic logic [5:0] global_id(input logic [1:0] cl, input logic [3:0] k);
        return ID_BASE[cl] + {1'b0, k[3:2], 1'b0, k[1:0]};
    endfunction

endpackage

// File: rtl/pe_alloc_scheduler_occ.sv
// Occupancy bitmap for one 4x4 cluster with set/clear/flush and popcount.
// Clear is applied after set, so it wins if both target the same bit.
module pe_cluster_occ (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        set_i,
    input  logic [3:0]  set_idx_i,
    input  logic        clr_i,
    input  logic [3:0]  clr_idx_i,
    output logic [15:0] bits_o,
    output logic [3:0]  count_o
);

    logic [15:0] bits_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            bits_q <= '0;
        end else begin
            if (set_i) bits_q[set_idx_i] <= 1'b1;
            if (clr_i) bits_q[clr_idx_i] <= 1'b0;
        end
    end

    // The controller bit is never set, so the count cannot exceed 15.
    always_comb begin
        count_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            count_o = count_o + {3'b000, bits_q[i]};
        end
    end

    assign bits_o = bits_q;

endmodule

// File: rtl/pe_alloc_scheduler.sv
// Task-to-PE allocator: picks a cluster by occupancy, then scans it for the
// idle PE closest to the cluster controller and returns its global id.
module pe_alloc_scheduler
    import pe_alloc_pkg::*;
#(
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned TH_OCC = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             app_end_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             gnt_valid_o,
    output logic             gnt_fail_o,
    output logic [TAG_W-1:0] gnt_tag_o,
    output logic [5:0]       gnt_pe_id_o,
    output logic [1:0]       gnt_cluster_o,
    input  logic             rel_valid_i,
    input  logic [5:0]       rel_pe_id_i,
    output logic             rel_err_o,
    output logic [6:0]       occ_total_o
);

    localparam logic [3:0] TH_OCC_W = 4'(TH_OCC);

    state_e             state_q;
    logic               req_ready_q;
    logic [TAG_W-1:0]   tag_q;
    logic [1:0]         cl_q;
    logic               fail_q;
    logic [3:0]         k_q;
    logic               found_q;
    logic [3:0]         best_k_q;
    logic [2:0]         best_d_q;
    logic               gnt_valid_q;
    logic               gnt_fail_q;
    logic [TAG_W-1:0]   gnt_tag_q;
    logic [5:0]         gnt_pe_id_q;
    logic [1:0]         gnt_cluster_q;
    logic               rel_err_q;
    logic [6:0]         occ_total_q;

    logic [3:0][15:0]   occ_bits;
    logic [3:0][3:0]    occ_cnt;
    logic [3:0]         set_en;
    logic [3:0]         clr_en;

    logic [1:0]         rel_cl;
    logic [3:0]         rel_k;
    logic               rel_hit;
    logic               rel_ok;

    logic [3:0]         stc_min;
    logic [1:0]         stc_idx;
    logic [1:0]         sel_cl_d;
    logic               sel_fail_d;

    logic               scan_cand;
    logic [2:0]         scan_dist;
    logic               found_d;
    logic [3:0]         best_k_d;
    logic [2:0]         best_d_d;

    // Cluster from the row/col MSBs: 00 MTC, 01 STC1, 11 STC2, 10 STC3.
    assign rel_cl  = {rel_pe_id_i[5], rel_pe_id_i[5] ^ rel_pe_id_i[2]};
    assign rel_k   = {rel_pe_id_i[4:3], rel_pe_id_i[1:0]};
    assign rel_hit = rel_valid_i && !app_end_i;
    assign rel_ok  = rel_hit && occ_bits[rel_cl][rel_k] && (rel_pe_id_i != CTRL_ID[rel_cl]);

    for (genvar g = 0; g < N_CL; g++) begin : g_cl
        assign set_en[g] = (state_q == ST_GRANT) && !fail_q && (cl_q == 2'(g));
        assign clr_en[g] = rel_ok && (rel_cl == 2'(g));

        pe_cluster_occ u_occ (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .flush_i   (app_end_i),
            .set_i     (set_en[g]),
            .set_idx_i (best_k_q),
            .clr_i     (clr_en[g]),
            .clr_idx_i (rel_k),
            .bits_o    (occ_bits[g]),
            .count_o   (occ_cnt[g])
        );
    end

    always_comb begin
        stc_min    = LOCAL_FULL;
        stc_idx    = CL_STC1;
        sel_cl_d   = CL_MTC;
        sel_fail_d = 1'b0;
        for (int i = 1; i < N_CL; i++) begin
            if (occ_cnt[i] < stc_min) begin
                stc_min = occ_cnt[i];
                stc_idx = 2'(i);
            end
        end
        if (occ_cnt[0] >= TH_OCC_W) begin
            if (stc_min < LOCAL_FULL) sel_cl_d = stc_idx;
            else                      sel_fail_d = (occ_cnt[0] == LOCAL_FULL);
        end
    end

    always_comb begin
        scan_cand = !occ_bits[cl_q][k_q] && (k_q != ctrl_k(cl_q));
        scan_dist = manhattan(k_q[3:2], k_q[1:0], CTRL_R[cl_q], CTRL_C[cl_q]);
        found_d   = found_q;
        best_k_d  = best_k_q;
        best_d_d  = best_d_q;
        if (scan_cand && (!found_q || scan_dist < best_d_q)) begin
            found_d  = 1'b1;
            best_k_d = k_q;
            best_d_d = scan_dist;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            tag_q         <= '0;
            cl_q          <= CL_MTC;
            fail_q        <= 1'b0;
            k_q           <= 4'd0;
            found_q       <= 1'b0;
            best_k_q      <= 4'd0;
            best_d_q      <= 3'd0;
            gnt_valid_q   <= 1'b0;
            gnt_fail_q    <= 1'b0;
            gnt_tag_q     <= '0;
            gnt_pe_id_q   <= 6'd0;
            gnt_cluster_q <= 2'd0;
        end else if (app_end_i) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            gnt_valid_q <= 1'b0;
            gnt_fail_q  <= 1'b0;
        end else begin
            gnt_valid_q <= 1'b0;
            gnt_fail_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        tag_q       <= req_tag_i;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    cl_q     <= sel_cl_d;
                    fail_q   <= sel_fail_d;
                    k_q      <= 4'd0;
                    found_q  <= 1'b0;
                    best_k_q <= 4'd0;
                    best_d_q <= 3'd0;
                    state_q  <= ST_SCAN;
                end
                ST_SCAN: begin
                    k_q      <= k_q + 4'd1;
                    found_q  <= found_d;
                    best_k_q <= best_k_d;
                    best_d_q <= best_d_d;
                    if (k_q == 4'd15) begin
                        state_q     <= ST_GRANT;
                        gnt_valid_q <= 1'b1;
                        gnt_tag_q   <= tag_q;
                        if (fail_q || !found_d) begin
                            fail_q        <= 1'b1;
                            gnt_fail_q    <= 1'b1;
                            gnt_pe_id_q   <= 6'd0;
                            gnt_cluster_q <= 2'd0;
                        end else begin
                            gnt_pe_id_q   <= global_id(cl_q, best_k_d);
                            gnt_cluster_q <= cl_q;
                        end
                    end
                end
                ST_GRANT: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rel_err_q   <= 1'b0;
            occ_total_q <= 7'd0;
        end else begin
            rel_err_q   <= rel_hit && !rel_ok;
            occ_total_q <= {3'b000, occ_cnt[0]} + {3'b000, occ_cnt[1]}
                         + {3'b000, occ_cnt[2]} + {3'b000, occ_cnt[3]};
        end
    end

    assign req_ready_o   = req_ready_q;
    assign gnt_valid_o   = gnt_valid_q;
    assign gnt_fail_o    = gnt_fail_q;
    assign gnt_tag_o     = gnt_tag_q;
    assign gnt_pe_id_o   = gnt_pe_id_q;
    assign gnt_cluster_o = gnt_cluster_q;
    assign rel_err_o     = rel_err_q;
    assign occ_total_o   = occ_total_q;

endmodule

// File: tb/tb_pe_alloc_scheduler.sv
// Directed bench for pe_alloc_scheduler: allocation order, latency, releases,
// full-mesh failure, app_end flush and synchronous reset mid-scan.
module tb_pe_alloc_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       app_end;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_tag;
    logic       gnt_valid;
    logic       gnt_fail;
    logic [7:0] gnt_tag;
    logic [5:0] gnt_pe_id;
    logic [1:0] gnt_cluster;
    logic       rel_valid;
    logic [5:0] rel_pe_id;
    logic       rel_err;
    logic [6:0] occ_total;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pe_alloc_scheduler #(.TAG_W(8), .TH_OCC(11)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .app_end_i     (app_end),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_tag_i     (req_tag),
        .gnt_valid_o   (gnt_valid),
        .gnt_fail_o    (gnt_fail),
        .gnt_tag_o     (gnt_tag),
        .gnt_pe_id_o   (gnt_pe_id),
        .gnt_cluster_o (gnt_cluster),
        .rel_valid_i   (rel_valid),
        .rel_pe_id_i   (rel_pe_id),
        .rel_err_o     (rel_err),
        .occ_total_o   (occ_total)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge with the DUT idle; returns 1 unit after
    // the edge that takes the DUT from GRANT back to IDLE.
    task automatic do_req(input logic [7:0] tag, output logic [5:0] pe,
                          output logic [1:0] cl, output logic fl, output int lat);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!gnt_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("gnt_seen", gnt_valid, 1);
        chk("gnt_tag", gnt_tag, tag);
        pe = gnt_pe_id;
        cl = gnt_cluster;
        fl = gnt_fail;
        tick();
        chk("gnt_pulse_len", gnt_valid, 0);
    endtask

    task automatic do_rel(input logic [5:0] id);
        rel_valid = 1'b1;
        rel_pe_id = id;
        tick();
        rel_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pe;
        logic [1:0] cl;
        logic       fl;
        int         lat;
        logic       seen;
        int         exp_mtc[11] = '{1, 8, 2, 9, 16, 3, 10, 17, 24, 11, 18};
        int         exp_rst[4]  = '{8, 2, 9, 16};

        rst = 1'b1; app_end = 1'b0; req_valid = 1'b0; req_tag = 8'd0;
        rel_valid = 1'b0; rel_pe_id = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_gnt_valid", gnt_valid, 0);
        chk("rst_gnt_fail", gnt_fail, 0);
        chk("rst_rel_err", rel_err, 0);
        chk("rst_gnt_tag", gnt_tag, 0);
        chk("rst_gnt_pe", gnt_pe_id, 0);
        chk("rst_gnt_cl", gnt_cluster, 0);
        chk("rst_occ", occ_total, 0);

        // MTC fills nearest-first from controller (0,0).
        for (int i = 0; i < 11; i++) begin
            do_req(8'(i + 1), pe, cl, fl, lat);
            chk("mtc_pe", pe, exp_mtc[i]);
            chk("mtc_cl", cl, 0);
            chk("mtc_fail", fl, 0);
            chk("mtc_latency", lat, 18);
            if (i == 2) begin
                tick();
                chk("occ_after3", occ_total, 3);
            end
        end

        // MTC at threshold: goes to STC1, local (0,2).
        do_req(8'd12, pe, cl, fl, lat);
        chk("stc1_pe", pe, 6);
        chk("stc1_cl", cl, 1);
        chk("stc1_fail", fl, 0);
        tick();
        chk("occ_after12", occ_total, 12);

        do_rel(6'd8);
        chk("rel8_err", rel_err, 0);
        tick();
        chk("rel8_occ", occ_total, 11);
        do_rel(6'd8);
        chk("rel8_again_err", rel_err, 1);
        tick();
        chk("rel8_again_err_clr", rel_err, 0);
        chk("rel8_again_occ", occ_total, 11);
        do_rel(6'd0);
        chk("rel0_err", rel_err, 1);
        tick();
        chk("rel0_occ", occ_total, 11);

        for (int i = 0; i < 49; i++) begin
            do_req(8'(100 + i), pe, cl, fl, lat);
            chk("fill_fail", fl, 0);
        end
        tick();
        chk("occ_full", occ_total, 60);

        do_req(8'hA5, pe, cl, fl, lat);
        chk("full_fail", fl, 1);
        chk("full_pe", pe, 0);
        chk("full_latency", lat, 18);
        tick();
        chk("occ_full_after", occ_total, 60);

        // app_end mid-SCAN with a controller release in the same cycle.
        req_valid = 1'b1;
        req_tag   = 8'h33;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        app_end   = 1'b1;
        rel_valid = 1'b1;
        rel_pe_id = 6'd0;
        tick();
        app_end   = 1'b0;
        rel_valid = 1'b0;
        chk("append_ready", req_ready, 1);
        chk("append_rel_err", rel_err, 0);
        seen = 1'b0;
        for (int j = 0; j < 25; j++) begin
            tick();
            if (gnt_valid) seen = 1'b1;
            if (j == 0) chk("append_occ", occ_total, 0);
        end
        chk("append_no_gnt", seen, 0);

        do_req(8'h55, pe, cl, fl, lat);
        chk("post_append_pe", pe, 1);
        chk("post_append_cl", cl, 0);
        for (int i = 0; i < 4; i++) begin
            do_req(8'(60 + i), pe, cl, fl, lat);
            chk("pre_rst_pe", pe, exp_rst[i]);
        end
        tick();
        chk("pre_rst_occ", occ_total, 5);

        req_valid = 1'b1;
        req_tag   = 8'h77;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_gnt_valid", gnt_valid, 0);
        chk("mid_rst_gnt_fail", gnt_fail, 0);
        chk("mid_rst_rel_err", rel_err, 0);
        chk("mid_rst_gnt_tag", gnt_tag, 0);
        chk("mid_rst_gnt_pe", gnt_pe_id, 0);
        chk("mid_rst_gnt_cl", gnt_cluster, 0);
        chk("mid_rst_occ", occ_total, 0);
        seen = 1'b0;
        for (int j = 0; j < 25; j++) begin
            tick();
            if (gnt_valid) seen = 1'b1;
        end
        chk("mid_rst_no_gnt", seen, 0);
        do_req(8'h09, pe, cl, fl, lat);
        chk("post_rst_pe", pe, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
